// File: rtl/logic_gate_pipe.sv
// CHANNELS parallel WIDTH-input gates with a run-time selectable function,
// a one-stage valid/ready output register and a saturating hit counter.
module logic_gate_pipe #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [2:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_data,
  input  logic                      cnt_clr,
  output logic [15:0]               hit_count
);

  localparam logic [2:0] MODE_AND  = 3'b000;
  localparam logic [2:0] MODE_OR   = 3'b001;
  localparam logic [2:0] MODE_XOR  = 3'b010;
  localparam logic [2:0] MODE_NAND = 3'b011;
  localparam logic [2:0] MODE_NOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;
  localparam logic [2:0] MODE_MAJ  = 3'b110;

  function automatic logic gate_eval(input logic [WIDTH-1:0] ops, input logic [2:0] fn);
    int pc;
    logic r;
    pc = 0;
    for (int i = 0; i < WIDTH; i++) pc = pc + int'(ops[i]);
    case (fn)
      MODE_AND:  r = &ops;
      MODE_OR:   r = |ops;
      MODE_XOR:  r = ^ops;
      MODE_NAND: r = ~&ops;
      MODE_NOR:  r = ~|ops;
      MODE_XNOR: r = ~^ops;
      // Strict majority: an even-WIDTH tie resolves to 0.
      MODE_MAJ:  r = (pc > WIDTH / 2);
      default:   r = ops[0];
    endcase
    return r;
  endfunction

  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] out_data_q, out_data_d;
  logic [15:0]         hit_count_q, hit_count_d;
  logic [CHANNELS-1:0] result;
  logic                accept;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    result = '0;
    for (int c = 0; c < CHANNELS; c++)
      result[c] = gate_eval(in_data[c*WIDTH +: WIDTH], mode);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    hit_count_d = hit_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cnt_clr)
      hit_count_d = '0;
    else if (accept && (|result) && (hit_count_q != 16'hFFFF))
      hit_count_d = hit_count_q + 16'd1;
  end

  // Output register and counter stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      hit_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: a WIDTH=2/CHANNELS=4 instance plus
// WIDTH=5 and WIDTH=4 single-channel instances for the majority function.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [7:0] in_data;
  logic [2:0] mode;
  logic [3:0] out_data;
  logic [15:0] hit_count;

  logic       m5_in_valid, m5_in_ready, m5_out_valid;
  logic [4:0] m5_in_data;
  logic [0:0] m5_out_data;
  logic [15:0] m5_hit_count;

  logic       m4_in_valid, m4_in_ready, m4_out_valid;
  logic [3:0] m4_in_data;
  logic [0:0] m4_out_data;
  logic [15:0] m4_hit_count;

  logic_gate_pipe #(.WIDTH(2), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cnt_clr(cnt_clr), .hit_count(hit_count)
  );

  logic_gate_pipe #(.WIDTH(5), .CHANNELS(1)) dut_m5 (
    .clk(clk), .rst(rst), .in_valid(m5_in_valid), .in_ready(m5_in_ready),
    .in_data(m5_in_data), .mode(3'b110), .out_valid(m5_out_valid), .out_ready(1'b1),
    .out_data(m5_out_data), .cnt_clr(1'b0), .hit_count(m5_hit_count)
  );

  logic_gate_pipe #(.WIDTH(4), .CHANNELS(1)) dut_m4 (
    .clk(clk), .rst(rst), .in_valid(m4_in_valid), .in_ready(m4_in_ready),
    .in_data(m4_in_data), .mode(3'b110), .out_valid(m4_out_valid), .out_ready(1'b1),
    .out_data(m4_out_data), .cnt_clr(1'b0), .hit_count(m4_hit_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 4'b1000; sweep_exp[1] = 4'b1110;
    sweep_exp[2] = 4'b0110; sweep_exp[3] = 4'b0111;
    sweep_exp[4] = 4'b0001; sweep_exp[5] = 4'b1001;
    sweep_exp[6] = 4'b1000; sweep_exp[7] = 4'b1010;

    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; mode = 3'b000;
    out_ready = 1'b0; cnt_clr = 1'b0;
    m5_in_valid = 1'b1; m5_in_data = 5'h1F; m4_in_valid = 1'b1; m4_in_data = 4'hF;

    // Reset held 3 cycles with in_valid high
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_m5_out_valid", m5_out_valid, 0);
    rst = 1'b0; in_valid = 1'b0; m5_in_valid = 1'b0; m4_in_valid = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Function sweep
    in_data = 8'b11_10_01_00; out_ready = 1'b1; in_valid = 1'b1;
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      step();
      chk($sformatf("sweep_mode%0d_data", m), out_data, sweep_exp[m]);
      chk($sformatf("sweep_mode%0d_valid", m), out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_hit_count", hit_count, 8);
    chk("sweep_drain", out_valid, 0);

    // Majority, WIDTH=5 and WIDTH=4
    m5_in_valid = 1'b1; m5_in_data = 5'b00111; m4_in_valid = 1'b1; m4_in_data = 4'b0011;
    step();
    chk("maj5_00111", m5_out_data, 1);
    chk("maj4_0011_tie", m4_out_data, 0);
    chk("maj4_valid", m4_out_valid, 1);
    m4_in_valid = 1'b0; m5_in_data = 5'b00011;
    step();
    chk("maj5_00011", m5_out_data, 0);
    m5_in_data = 5'b11111;
    step();
    chk("maj5_11111", m5_out_data, 1);
    m5_in_valid = 1'b0;

    // Backpressure
    cnt_clr = 1'b1;
    step();
    chk("clr_hit_count", hit_count, 0);
    cnt_clr = 1'b0;
    in_valid = 1'b1; mode = 3'b000; in_data = 8'hFF;
    step();
    chk("bp_a_data", out_data, 4'hF);
    out_ready = 1'b0; in_data = 8'h0F;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp_hold%0d_data", i), out_data, 4'hF);
      chk($sformatf("bp_hold%0d_valid", i), out_valid, 1);
      chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
    end
    chk("bp_hold_hits", hit_count, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_ready, 1);
    step();
    chk("bp_b_data", out_data, 4'b0011);
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_hits", hit_count, 2);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 0);

    // Counter: 10 non-zero, 5 zero results
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; in_valid = 1'b1; mode = 3'b000;
    for (int i = 0; i < 15; i++) begin
      in_data = (i < 10) ? 8'hFF : 8'h00;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt_ten", hit_count, 10);
    in_valid = 1'b1; in_data = 8'hFF; cnt_clr = 1'b1;
    step();
    chk("cnt_clr_priority", hit_count, 0);
    chk("cnt_clr_accept_data", out_data, 4'hF);
    cnt_clr = 1'b0;

    // Saturation
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_preload", hit_count, 16'hFFFE);
    step();
    chk("sat_reach", hit_count, 16'hFFFF);
    step();
    chk("sat_hold1", hit_count, 16'hFFFF);
    step();
    chk("sat_hold2", hit_count, 16'hFFFF);

    // Reset mid-operation with a pending result
    in_data = 8'h0F;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    step();
    chk("mid_full", out_valid, 1);
    chk("mid_full_data", out_data, 4'b0011);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_hits", hit_count, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("mid_no_pending", out_valid, 0);
    chk("mid_hits_after", hit_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
